// File: rtl/vram_capture_if.sv
// ---------------------------------------------------------------------------
// vram_capture_if
//
// Purpose: groups the two bus-style connections of vram_capture.
//   - The snooped 6502-style CPU bus (phi2, rwb, address, data).
//   - The VRAM read port used by the diagnostics block (address in, data and
//     active screen size out).
//
// Signals:
//   cpu_phi2      CPU phase-2 clock, asynchronous to fpga_clk
//   cpu_rwb       CPU read/not-write, asynchronous
//   cpu_address   CPU address bus (16 bits), asynchronous
//   cpu_data      CPU data bus (8 bits), asynchronous
//   vram_address  read address from diagnostics (11 bits)
//   vram_data     registered read data (8 bits)
//   vram_size     active screen size in bytes (11 bits)
//
// Modports:
//   master  the environment side: drives the CPU bus and the read address
//   slave   vram_capture itself: samples the bus, returns data and size
// ---------------------------------------------------------------------------
interface vram_capture_if;
    logic        cpu_phi2;
    logic        cpu_rwb;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic [10:0] vram_address;
    logic [7:0]  vram_data;
    logic [10:0] vram_size;

    modport master (
        output cpu_phi2,
        output cpu_rwb,
        output cpu_address,
        output cpu_data,
        output vram_address,
        input  vram_data,
        input  vram_size
    );

    modport slave (
        input  cpu_phi2,
        input  cpu_rwb,
        input  cpu_address,
        input  cpu_data,
        input  vram_address,
        output vram_data,
        output vram_size
    );
endinterface

// File: rtl/vram_capture.sv
// ---------------------------------------------------------------------------
// vram_capture
//
// Purpose: bus-snooping mirror of the target machine's screen memory. Every
// CPU write that lands in the screen window is copied into a 2048x8 RAM,
// which the diagnostics block reads back through the VRAM read port. A
// fill sweep writes FILL_BYTE to the whole RAM so a stale image is never
// dumped after a configuration change.
//
// Ports:
//   fpga_clk     system clock, all logic on its rising edge
//   fpga_reset   asynchronous active-high reset
//   bus          vram_capture_if.slave: CPU bus in, VRAM read port
//   capture_en   1 = capture CPU writes, 0 = drop them
//   size_select  0 = SIZE_40 screen, 1 = SIZE_80 screen
//   clear_req    single-cycle pulse starting a fill sweep
//   clear_busy   high while the fill sweep runs
// ---------------------------------------------------------------------------
module vram_capture #(
    parameter logic [15:0] VRAM_BASE = 16'h8000,
    parameter logic [7:0]  FILL_BYTE = 8'h20,
    parameter logic [10:0] SIZE_40   = 11'd1000,
    parameter logic [10:0] SIZE_80   = 11'd2000
) (
    input  logic                 fpga_clk,
    input  logic                 fpga_reset,
    vram_capture_if.slave        bus,
    input  logic                 capture_en,
    input  logic                 size_select,
    input  logic                 clear_req,
    output logic                 clear_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Synchroniser stages; s3 holds the previous synchronised sample so the
    // address/data/rwb used on a phi2 fall are those seen while phi2 was high.
    logic        r_s1_phi2, r_s2_phi2, r_s3_phi2;
    logic        r_s1_rwb,  r_s2_rwb,  r_s3_rwb;
    logic [15:0] r_s1_addr, r_s2_addr, r_s3_addr;
    logic [7:0]  r_s1_data, r_s2_data, r_s3_data;

    logic [7:0]  r_ram [0:2047];
    logic [7:0]  r_vram_data;
    logic [10:0] r_vram_size;

    state_t      r_state;
    state_t      w_state_next;
    logic [10:0] r_clr_addr;
    logic [10:0] w_clr_addr_next;

    logic        w_fall;
    logic [15:0] w_off;
    logic        w_hit;
    logic        w_fill_we;
    logic        w_we;
    logic [10:0] w_waddr;
    logic [7:0]  w_wdata;

    // Three-stage capture of the asynchronous CPU bus. Reset clears every
    // stage, including phi2, so no false falling edge appears after reset.
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            r_s1_phi2 <= 1'b0;
            r_s2_phi2 <= 1'b0;
            r_s3_phi2 <= 1'b0;
            r_s1_rwb  <= 1'b0;
            r_s2_rwb  <= 1'b0;
            r_s3_rwb  <= 1'b0;
            r_s1_addr <= 16'h0000;
            r_s2_addr <= 16'h0000;
            r_s3_addr <= 16'h0000;
            r_s1_data <= 8'h00;
            r_s2_data <= 8'h00;
            r_s3_data <= 8'h00;
        end else begin
            r_s1_phi2 <= bus.cpu_phi2;
            r_s2_phi2 <= r_s1_phi2;
            r_s3_phi2 <= r_s2_phi2;
            r_s1_rwb  <= bus.cpu_rwb;
            r_s2_rwb  <= r_s1_rwb;
            r_s3_rwb  <= r_s2_rwb;
            r_s1_addr <= bus.cpu_address;
            r_s2_addr <= r_s1_addr;
            r_s3_addr <= r_s2_addr;
            r_s1_data <= bus.cpu_data;
            r_s2_data <= r_s1_data;
            r_s3_data <= r_s2_data;
        end
    end

    // Window check: addresses below VRAM_BASE wrap to a large offset and
    // therefore fail the size comparison without a separate lower bound.
    always_comb begin
        w_fall = r_s3_phi2 & ~r_s2_phi2;
        w_off  = r_s3_addr - VRAM_BASE;
        w_hit  = w_fall & ~r_s3_rwb & capture_en & (w_off < {5'd0, r_vram_size});
    end

    // Clear FSM: state and sweep counter registers.
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            r_state    <= IDLE;
            r_clr_addr <= 11'd0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // Clear FSM: next state. A capture write steals the RAM port, so the
    // sweep holds its address and retries the fill on the following cycle.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_next    = CLEAR;
                    w_clr_addr_next = 11'd0;
                end
            end
            CLEAR: begin
                if (!w_hit) begin
                    w_clr_addr_next = r_clr_addr + 11'd1;
                    if (r_clr_addr == 11'd2047) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Clear FSM: outputs. clear_busy decodes the state flop directly.
    always_comb begin
        w_fill_we  = (r_state == CLEAR) && !w_hit;
        clear_busy = (r_state == CLEAR);
    end

    // Single RAM write port shared by capture (priority) and the fill sweep.
    always_comb begin
        w_we    = w_hit | w_fill_we;
        w_waddr = w_hit ? w_off[10:0] : r_clr_addr;
        w_wdata = w_hit ? r_s3_data : FILL_BYTE;
    end

    // Mirror RAM, deliberately without reset: contents are undefined until
    // written or swept, and reset during a sweep leaves partial contents.
    always_ff @(posedge fpga_clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= w_wdata;
        end
    end

    // Read port and size register. The read samples the RAM before this
    // edge's write lands, so a same-address collision returns the old byte.
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            r_vram_data <= 8'h00;
            r_vram_size <= SIZE_40;
        end else begin
            r_vram_data <= r_ram[bus.vram_address];
            r_vram_size <= size_select ? SIZE_80 : SIZE_40;
        end
    end

    assign bus.vram_data = r_vram_data;
    assign bus.vram_size = r_vram_size;

endmodule
